// File: rtl/adbg_top_hub.sv
// -----------------------------------------------------------------------------
// adbg_top_hub
//
// Top-level chain selector of the advanced debug unit.  It owns the main DR
// input shift register and the module-ID register, and it decodes a one-hot
// select for up to NB_MODULES debug sub-modules.  When a populated module is
// selected, that module's TDO is routed onto the chain.  Otherwise, a 16-bit
// hub status word is shifted out on TDO.
//
// Ports
//   tck_i            JTAG TCK, the only clock
//   rst_i            synchronous active-high reset
//   tdi_i            JTAG TDI
//   tdo_o            chain TDO (combinational mux)
//   capture_dr_i     TAP in Capture-DR
//   shift_dr_i       TAP in Shift-DR
//   update_dr_i      TAP in Update-DR
//   debug_select_i   DEBUG instruction active in the IR
//   data_register_o  input shift register contents, fanned out to sub-modules
//   module_select_o  one-hot module select
//   module_inhibit_i per-module inhibit of a new selection
//   module_tdo_i     per-module TDO
//   module_id_o      currently latched module ID
//   select_valid_o   a populated module is selected
//   select_err_o     sticky: last select addressed an absent/out-of-range ID
// -----------------------------------------------------------------------------
module adbg_top_hub #(
   parameter int                    NB_MODULES     = 4,
   parameter int                    MODULE_ID_LEN  = 2,
   parameter int                    DATAREG_LEN    = 64,
   parameter logic [NB_MODULES-1:0] MODULE_PRESENT = {NB_MODULES{1'b1}}
) (
   input  logic                     tck_i,
   input  logic                     rst_i,
   input  logic                     tdi_i,
   output logic                     tdo_o,
   input  logic                     capture_dr_i,
   input  logic                     shift_dr_i,
   input  logic                     update_dr_i,
   input  logic                     debug_select_i,
   output logic [DATAREG_LEN-1:0]   data_register_o,
   output logic [NB_MODULES-1:0]    module_select_o,
   input  logic [NB_MODULES-1:0]    module_inhibit_i,
   input  logic [NB_MODULES-1:0]    module_tdo_i,
   output logic [MODULE_ID_LEN-1:0] module_id_o,
   output logic                     select_valid_o,
   output logic                     select_err_o
);

   // State registers
   logic [DATAREG_LEN-1:0]   r_sreg;
   logic [MODULE_ID_LEN-1:0] r_module_id;
   logic                     r_select_valid;
   logic                     r_select_err;
   logic                     r_inhibit_hit;
   logic [15:0]              r_status_sr;

   // Command decode and control strobes
   logic                     w_select_cmd;
   logic [MODULE_ID_LEN-1:0] w_id_in;
   logic                     w_id_valid;
   logic                     w_inhibited;
   logic                     w_dr_shift;
   logic                     w_select_update;
   logic                     w_status_capture;
   logic                     w_status_shift;
   logic [15:0]              w_status_word;
   logic [NB_MODULES-1:0]    w_module_select;
   logic                     w_module_tdo;

   assign w_select_cmd = r_sreg[DATAREG_LEN-1];
   assign w_id_in      = r_sreg[DATAREG_LEN-2 -: MODULE_ID_LEN];
   assign w_inhibited  = |module_inhibit_i;

   assign w_dr_shift       = debug_select_i && shift_dr_i;
   assign w_select_update  = debug_select_i && update_dr_i && w_select_cmd;
   assign w_status_capture = debug_select_i && capture_dr_i && !r_select_valid;
   assign w_status_shift   = debug_select_i && shift_dr_i && !r_select_valid;

   // An ID is valid only when it matches a populated slot.  IDs at or above
   // NB_MODULES match no slot at all, so the range check falls out of the loop.
   always_comb begin
      w_id_valid = 1'b0;
      for (int i = 0; i < NB_MODULES; i++) begin
         if (w_id_in == MODULE_ID_LEN'(i)) w_id_valid = MODULE_PRESENT[i];
      end
   end

   // The select is one-hot by construction.  It is derived from a single
   // latched ID and is gated by select_valid.
   always_comb begin
      w_module_select = '0;
      w_module_tdo    = 1'b0;
      for (int i = 0; i < NB_MODULES; i++) begin
         if (r_module_id == MODULE_ID_LEN'(i)) begin
            w_module_select[i] = r_select_valid;
            w_module_tdo       = module_tdo_i[i];
         end
      end
   end

   assign w_status_word = {4'hA, r_select_err, r_inhibit_hit, r_select_valid,
                           1'b0, 8'(r_module_id)};

   always_ff @(posedge tck_i) begin
      // NOTE: reset is synchronous.  It sits inside the clocked block so that it
      // overrides every other update on the same TCK edge.
      if (rst_i) begin
         r_sreg         <= '0;
         r_module_id    <= '0;
         r_select_valid <= 1'b0;
         r_select_err   <= 1'b0;
         r_inhibit_hit  <= 1'b0;
         r_status_sr    <= '0;
      end else begin
         // LSB-first shifting: TDI enters at the MSB, so the command bit ends
         // up on top once the full DR has been shifted in.
         if (w_dr_shift) r_sreg <= {tdi_i, r_sreg[DATAREG_LEN-1:1]};

         // Capture reads pre-update state.  That holds even if Update-DR
         // is asserted on the same edge.
         if (w_status_capture) begin
            r_status_sr   <= w_status_word;
            r_inhibit_hit <= 1'b0;
         end else if (w_status_shift) begin
            r_status_sr   <= {1'b0, r_status_sr[15:1]};
         end

         // NOTE: non-blocking assignments.  The last one in program order wins,
         // so an inhibit hit set below beats the read-to-clear above.
         if (w_select_update) begin
            if (w_inhibited) begin
               r_inhibit_hit  <= 1'b1;
            end else if (!w_id_valid) begin
               r_module_id    <= w_id_in;
               r_select_valid <= 1'b0;
               r_select_err   <= 1'b1;
            end else begin
               r_module_id    <= w_id_in;
               r_select_valid <= 1'b1;
               r_select_err   <= 1'b0;
            end
         end
      end
   end

   assign tdo_o           = r_select_valid ? w_module_tdo : r_status_sr[0];
   assign data_register_o = r_sreg;
   assign module_select_o = w_module_select;
   assign module_id_o     = r_module_id;
   assign select_valid_o  = r_select_valid;
   assign select_err_o    = r_select_err;

endmodule

// File: tb/tb_adbg_top_hub.sv
// -----------------------------------------------------------------------------
// tb_adbg_top_hub
//
// Directed bench for adbg_top_hub.  It drives two instances from the same TAP
// stimulus:
//   u_full - all four modules populated
//   u_part - MODULE_PRESENT = 4'b1011 (module 2 absent)
// The same commands exercise the valid-select and error paths side by side.
// -----------------------------------------------------------------------------
module tb_adbg_top_hub;

   localparam int DL = 64;

   logic          tck = 1'b0;
   logic          rst = 1'b0;
   logic          tdi = 1'b0;
   logic          capture_dr = 1'b0;
   logic          shift_dr = 1'b0;
   logic          update_dr = 1'b0;
   logic          debug_select = 1'b0;
   logic [3:0]    module_inhibit = '0;
   logic [3:0]    module_tdo = '0;

   logic          tdo_full, tdo_part;
   logic [DL-1:0] dreg_full, dreg_part;
   logic [3:0]    sel_full, sel_part;
   logic [1:0]    id_full, id_part;
   logic          valid_full, valid_part, err_full, err_part;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 tck = ~tck;

   adbg_top_hub #(.MODULE_PRESENT(4'b1111)) u_full (
      .tck_i(tck), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdo_full),
      .capture_dr_i(capture_dr), .shift_dr_i(shift_dr), .update_dr_i(update_dr),
      .debug_select_i(debug_select), .data_register_o(dreg_full),
      .module_select_o(sel_full), .module_inhibit_i(module_inhibit),
      .module_tdo_i(module_tdo), .module_id_o(id_full),
      .select_valid_o(valid_full), .select_err_o(err_full)
   );

   adbg_top_hub #(.MODULE_PRESENT(4'b1011)) u_part (
      .tck_i(tck), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdo_part),
      .capture_dr_i(capture_dr), .shift_dr_i(shift_dr), .update_dr_i(update_dr),
      .debug_select_i(debug_select), .data_register_o(dreg_part),
      .module_select_o(sel_part), .module_inhibit_i(module_inhibit),
      .module_tdo_i(module_tdo), .module_id_o(id_part),
      .select_valid_o(valid_part), .select_err_o(err_part)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one TCK edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   function automatic logic [DL-1:0] cmd_vec(input logic sel, input logic [1:0] id);
      logic [DL-1:0] v;
      v = '0;
      v[DL-1] = sel;
      v[DL-2 -: 2] = id;
      return v;
   endfunction

   // Shift bits [first, first+n) of v into the DR, LSB first.
   task automatic shift_bits(input logic [DL-1:0] v, input int first, input int n);
      debug_select = 1'b1;
      shift_dr = 1'b1;
      for (int i = first; i < first + n; i++) begin
         tdi = v[i];
         tick();
      end
      shift_dr = 1'b0;
      tdi = 1'b0;
   endtask

   task automatic pulse_update();
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
   endtask

   task automatic send_cmd(input logic sel, input logic [1:0] id);
      shift_bits(cmd_vec(sel, id), 0, DL);
      pulse_update();
   endtask

   // Capture-DR followed by 16 shifts.  TDO is sampled before each shift edge.
   task automatic read_status(output logic [15:0] wf, output logic [15:0] wp);
      debug_select = 1'b1;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wf[i] = tdo_full;
         wp[i] = tdo_part;
         tick();
      end
      shift_dr = 1'b0;
   endtask

   logic [15:0] st_f, st_p;
   logic [DL-1:0] junk;

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_sel",   sel_full,   4'b0000);
      check("rst_tdo",   tdo_full,   1'b0);
      check("rst_dreg",  dreg_full,  64'h0);
      check("rst_valid", valid_full, 1'b0);
      check("rst_err",   err_full,   1'b0);
      check("rst_id",    id_full,    2'd0);

      // ---------------- status after reset ----------------
      read_status(st_f, st_p);
      check("st_reset_full", st_f, 16'hA000);
      check("st_reset_part", st_p, 16'hA000);
      check("st_reset_sel",  sel_full, 4'b0000);

      // ---------------- select ID 2 ----------------
      shift_bits(cmd_vec(1'b1, 2'd2), 0, DL);
      check("dreg_cmd2", dreg_full, 64'hC000_0000_0000_0000);
      pulse_update();
      check("sel2_full",   sel_full,   4'b0100);
      check("sel2_valid",  valid_full, 1'b1);
      check("sel2_err",    err_full,   1'b0);
      module_tdo = 4'b0100;
      #1;
      check("tdo_mod2_hi", tdo_full, 1'b1);
      tick();
      module_tdo = 4'b1011;
      #1;
      check("tdo_mod2_lo", tdo_full, 1'b0);
      tick();
      module_tdo = 4'b0000;
      // The same ID is absent on the partial build.
      check("abs2_valid", valid_part, 1'b0);
      check("abs2_err",   err_part,   1'b1);
      check("abs2_id",    id_part,    2'd2);
      check("abs2_sel",   sel_part,   4'b0000);
      read_status(st_f, st_p);
      check("st_abs2", st_p, 16'hA802);
      check("tdo_after16", tdo_part, 1'b0);

      // ---------------- inhibit ----------------
      send_cmd(1'b1, 2'd1);
      check("sel1_full", sel_full, 4'b0010);
      check("sel1_part", sel_part, 4'b0010);
      check("sel1_err_cleared", err_part, 1'b0);
      module_inhibit = 4'b0010;
      send_cmd(1'b1, 2'd3);
      check("inh_sel_full", sel_full, 4'b0010);
      check("inh_sel_part", sel_part, 4'b0010);
      check("inh_id_part",  id_part,  2'd1);
      module_inhibit = 4'b0000;
      send_cmd(1'b1, 2'd2);
      check("desel_valid", valid_part, 1'b0);
      check("desel_err",   err_part,   1'b1);
      check("resel_full",  sel_full,   4'b0100);
      read_status(st_f, st_p);
      check("st_inh_hit", st_p, 16'hAC02);
      read_status(st_f, st_p);
      check("st_inh_rtc", st_p, 16'hA802);

      // ---------------- MSB=0 update leaves hub alone ----------------
      send_cmd(1'b1, 2'd0);
      check("sel0_part", sel_part, 4'b0001);
      send_cmd(1'b0, 2'd3);
      check("nocmd_id",    id_part,    2'd0);
      check("nocmd_valid", valid_part, 1'b1);
      check("nocmd_sel",   sel_full,   4'b0001);

      // ---------------- reset mid-shift ----------------
      junk = '1;
      shift_bits(junk, 0, 30);
      debug_select = 1'b1;
      shift_dr = 1'b1;
      tdi = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      shift_dr = 1'b0;
      check("mid_rst_dreg",  dreg_full,  64'h0);
      check("mid_rst_valid", valid_full, 1'b0);
      check("mid_rst_sel",   sel_part,   4'b0000);
      shift_bits(cmd_vec(1'b1, 2'd1), 30, 34);
      check("post_rst_dreg", dreg_full, 64'hA000_0000_0000_0000);
      pulse_update();
      check("post_rst_sel", sel_full, 4'b0010);
      check("post_rst_id",  id_part,  2'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adbg_top_hub.md
Name: adbg_top_hub

Overview:
- Parametrised successor of the fixed 4-module debug top-level chain selector.
- Owns the main DR input shift register and the module-ID register, and decodes a one-hot select for NB_MODULES debug sub-modules.
- Muxes sub-module TDO back onto the chain.
- Adds population masking, select-error reporting and a top-level status word, shifted out on TDO while no module is selected.

Parameters:
- NB_MODULES, 4: number of attachable debug sub-modules (1..256).
- MODULE_ID_LEN, 2: module-ID field width; must satisfy 2**MODULE_ID_LEN >= NB_MODULES and MODULE_ID_LEN <= 8.
- DATAREG_LEN, 64: length of the main input shift register; must be >= MODULE_ID_LEN+1.
- MODULE_PRESENT, {NB_MODULES{1'b1}}: bit i set means sub-module i is populated.

Ports:
- tck_i  in  1  JTAG TCK; the block's only clock.
- rst_i  in  1  synchronous active-high reset.
- tdi_i  in  1  JTAG TDI.
- tdo_o  out  1  chain TDO (combinational mux).
- capture_dr_i  in  1  TAP in Capture-DR.
- shift_dr_i  in  1  TAP in Shift-DR.
- update_dr_i  in  1  TAP in Update-DR.
- debug_select_i  in  1  DEBUG instruction active in the IR.
- data_register_o  out  DATAREG_LEN  input shift register contents, fanned out to sub-modules.
- module_select_o  out  NB_MODULES  one-hot module select.
- module_inhibit_i  in  NB_MODULES  per-module inhibit of a new selection.
- module_tdo_i  in  NB_MODULES  per-module TDO.
- module_id_o  out  MODULE_ID_LEN  currently latched module ID.
- select_valid_o  out  1  a populated module is selected.
- select_err_o  out  1  sticky: last select command addressed an absent or out-of-range ID.

Behaviour:
- Reset and clocking:
  - Every register updates on posedge tck_i.
  - rst_i wins over all other inputs.
  - Reset values: shift register 0, module_id 0, select_valid 0, select_err 0, inhibit_hit 0, status_sr 0.
  - Consequence: after reset module_select_o=0 and tdo_o=0.
- Input shift register:
  - When debug_select_i && shift_dr_i: sreg <= {tdi_i, sreg[DATAREG_LEN-1:1]} (LSB-first, TDI enters at the MSB).
  - Otherwise it holds.
  - data_register_o = sreg.
- Command decode:
  - select_cmd = sreg[DATAREG_LEN-1].
  - id_in = sreg[DATAREG_LEN-2 -: MODULE_ID_LEN].
- Select update, evaluated when debug_select_i && update_dr_i && select_cmd. Priority order:
  1. If |module_inhibit_i: ID, valid and err are unchanged; inhibit_hit <= 1.
  2. Else if id_in >= NB_MODULES or !MODULE_PRESENT[id_in]: module_id <= id_in, select_valid <= 0, select_err <= 1.
  3. Else: module_id <= id_in, select_valid <= 1, select_err <= 0.
- When select_cmd=0, Update-DR does not touch hub state; that command belongs to the selected sub-module.
- Select outputs:
  - module_select_o[i] = select_valid && (module_id == i).
  - The select is never multi-hot.
- Status word (16 bits): {4'hA, select_err, inhibit_hit, select_valid, 1'b0, module_id zero-extended to 8}.
- Status capture:
  - When debug_select_i && capture_dr_i && !select_valid: status_sr <= status word.
  - The same edge clears inhibit_hit (read-to-clear). A new inhibit_hit set on that same edge takes precedence over the clear.
  - select_err is not cleared by capture; only a valid select or reset clears it.
- Status shift:
  - When debug_select_i && shift_dr_i && !select_valid: status_sr <= {1'b0, status_sr[15:1]}.
  - After 16 shifts TDO reads 0.
- TDO mux:
  - tdo_o = select_valid ? module_tdo_i[module_id] : status_sr[0].
  - This holds irrespective of debug_select_i.
- Simultaneous update_dr_i and capture_dr_i (illegal from a TAP, defined anyway): the update is applied, and the capture uses pre-update state.
- No pause handling: the shift registers simply hold when shift_dr_i=0.
- Reset mid-shift: all state returns to reset values on the next edge, and a partial command is discarded.

Test Plan:
- Reset, then Capture-DR and 16 shifts with debug_select_i=1 -> TDO bits LSB-first = 0x00, 0x0A upper nibble; word 0xA000; module_select_o=0.
- Shift a 64-bit DR with MSB=1 and ID field=2, then Update-DR -> module_select_o=4'b0100, select_valid_o=1, tdo_o follows module_tdo_i[2] toggled 0/1 on consecutive cycles.
- MODULE_PRESENT=4'b1011, select ID 2 -> select_valid_o=0, select_err_o=1, module_id_o=2; Capture plus shift -> status 0xA802.
- Module 1 selected, module_inhibit_i=4'b0010, select command for ID 3 -> module_select_o stays 4'b0010; deselect later via ID 2 (absent) -> capture shows inhibit_hit=1 (0xA402 pattern with err=1: 0xAC02); second capture -> inhibit bit 0 (0xA802).
- Select cmd with MSB=0 and Update-DR while module 0 selected -> no change to module_id_o or select_valid_o.
- Assert rst_i after 30 shift cycles of a select command -> next edge: data_register_o=0, select_valid_o=0; completing the remaining shifts plus Update selects only based on bits shifted after reset.
